// File: rtl/cli_char_writer_if.sv
// Port bundle for cli_char_writer: character stream in, cursor tracker link, VRAM write port.
// master = the surrounding system, slave = the writer.
interface cli_char_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic [6:0]        x_pos;
  logic [5:0]        y_pos;
  logic              inc_ptr;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              busy;

  modport master (
    output char_valid, char_data, x_pos, y_pos,
    input  char_ready, inc_ptr, vram_we, vram_addr, vram_wdata, busy
  );

  modport slave (
    input  char_valid, char_data, x_pos, y_pos,
    output char_ready, inc_ptr, vram_we, vram_addr, vram_wdata, busy
  );
endinterface

// File: rtl/cli_char_writer.sv
// Console write stage: FIFO-buffered chars written to text VRAM at the cursor, then inc_ptr.
// Define CLI_CLEAR_EN to make 0x0C clear the whole screen to spaces.
module cli_char_writer #(
  parameter int unsigned COLS       = 100,
  parameter int unsigned ROWS       = 38,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 12
) (
  input logic             clk,
  input logic             rst_n,
  cli_char_writer_if.slave bus
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned Cells = COLS * ROWS;

  if (Cells > (1 << ADDR_W)) begin : g_cells_check
    $error("cli_char_writer: COLS*ROWS does not fit in ADDR_W bits");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StAdv,
    StSettle,
`ifdef CLI_CLEAR_EN
    StNl,
    StClr
`else
    StNl
`endif
  } state_e;

  // FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop;

  // FSM
  state_e            state_q, state_d;
  logic [7:0]        char_q, char_d;
  logic              nl_q, nl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] cell_addr;
  logic              we, inc;

  assign full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.char_valid & ~full;
  assign pop   = (state_q == StIdle) & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.char_data;
  end

  assign cell_addr = ADDR_W'(bus.y_pos) * ADDR_W'(COLS) + ADDR_W'(bus.x_pos);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      char_q  <= '0;
      nl_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      nl_q    <= nl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    nl_d    = nl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we      = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          char_d  = mem_q[rd_ptr_q];
          state_d = StLoad;
        end
      end
      // addr/wdata only move on the way into a write so they hold while vram_we is low
      StLoad: begin
        if (char_q == 8'h0A) begin
          nl_d    = 1'b1;
          state_d = StNl;
`ifdef CLI_CLEAR_EN
        end else if (char_q == 8'h0C) begin
          addr_d  = '0;
          wdata_d = 8'h20;
          state_d = StClr;
`endif
        end else begin
          addr_d  = cell_addr;
          wdata_d = char_q;
          state_d = StWrite;
        end
      end
      StWrite: begin
        we      = 1'b1;
        state_d = StAdv;
      end
      StAdv: begin
        inc     = 1'b1;
        state_d = StSettle;
      end
      StSettle: begin
        if (nl_q && (bus.x_pos != 7'd0)) begin
          state_d = StAdv;
        end else begin
          nl_d    = 1'b0;
          state_d = StIdle;
        end
      end
      StNl: state_d = StAdv;
`ifdef CLI_CLEAR_EN
      StClr: begin
        we = 1'b1;
        if (addr_q == ADDR_W'(Cells - 1)) state_d = StIdle;
        else                              addr_d  = addr_q + 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.char_ready = ~full;
  assign bus.inc_ptr    = inc;
  assign bus.vram_we    = we;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.busy       = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_cli_char_writer.sv
// Directed bench for cli_char_writer with a behavioural cursor tracker (one-cycle registered update).
module tb_cli_char_writer;
  localparam int unsigned Cols  = 100;
  localparam int unsigned Rows  = 38;
  localparam int unsigned Depth = 8;
  localparam int unsigned AddrW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cli_char_writer_if #(.ADDR_W(AddrW)) bus ();

  cli_char_writer #(
    .COLS      (Cols),
    .ROWS      (Rows),
    .FIFO_DEPTH(Depth),
    .ADDR_W    (AddrW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Cursor tracker model
  logic       set_req = 1'b0;
  logic [6:0] set_x   = '0;
  logic [5:0] set_y   = '0;

  always @(posedge clk) begin
    if (set_req) begin
      bus.x_pos <= set_x;
      bus.y_pos <= set_y;
    end else if (bus.inc_ptr) begin
      if (bus.x_pos == 7'(Cols - 1)) begin
        bus.x_pos <= '0;
        bus.y_pos <= (bus.y_pos == 6'(Rows - 1)) ? 6'd0 : bus.y_pos + 6'd1;
      end else begin
        bus.x_pos <= bus.x_pos + 7'd1;
      end
    end
  end

  // Write / pulse log, sampled on the falling edge
  int                cyc    = 0;
  int                we_n   = 0;
  int                inc_n  = 0;
  int                both_n = 0;
  logic [AddrW-1:0]  wa [4096];
  logic [7:0]        wd [4096];
  int                wc [4096];
  int                ic [4096];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.vram_we === 1'b1) begin
      wa[we_n % 4096] <= bus.vram_addr;
      wd[we_n % 4096] <= bus.vram_wdata;
      wc[we_n % 4096] <= cyc;
      we_n            <= we_n + 1;
    end
    if (bus.inc_ptr === 1'b1) begin
      ic[inc_n % 4096] <= cyc;
      inc_n            <= inc_n + 1;
    end
    if (bus.vram_we === 1'b1 && bus.inc_ptr === 1'b1) both_n <= both_n + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cursor(input logic [6:0] x, input logic [5:0] y);
    set_x   = x;
    set_y   = y;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    step();
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    step();
    while (bus.busy === 1'b1 && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, bus.busy, k);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = '0;
    set_cursor(7'd0, 6'd0);
    step();
    n_cmp += 6;
    if (bus.vram_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_we: got %b, required 0", bus.vram_we);
    end
    if (bus.inc_ptr !== 1'b0) begin
      n_bad++; $display("FAIL reset_inc: got %b, required 0", bus.inc_ptr);
    end
    if (bus.vram_addr !== '0) begin
      n_bad++; $display("FAIL reset_addr: got %0d, required 0", bus.vram_addr);
    end
    if (bus.vram_wdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_wdata: got %h, required 00", bus.vram_wdata);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    if (bus.char_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b, required 1", bus.char_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int we0, inc0;
    set_cursor(7'd5, 6'd2);
    we0  = we_n;
    inc0 = inc_n;
    push_char(8'h41);
    wait_idle(40, "single");
    n_cmp += 5;
    if (we_n - we0 != 1) begin
      n_bad++; $display("FAIL single_we_cnt: got %0d, required 1", we_n - we0);
    end
    if (inc_n - inc0 != 1) begin
      n_bad++; $display("FAIL single_inc_cnt: got %0d, required 1", inc_n - inc0);
    end
    if (wa[we0 % 4096] !== 12'd205) begin
      n_bad++; $display("FAIL single_addr: got %0d, required 205", wa[we0 % 4096]);
    end
    if (wd[we0 % 4096] !== 8'h41) begin
      n_bad++; $display("FAIL single_wdata: got %h, required 41", wd[we0 % 4096]);
    end
    if (ic[inc0 % 4096] - wc[we0 % 4096] != 1) begin
      n_bad++;
      $display("FAIL single_gap: inc-we cycles %0d, required 1",
               ic[inc0 % 4096] - wc[we0 % 4096]);
    end
    // outputs hold after the write
    n_cmp++;
    if (bus.vram_addr !== 12'd205 || bus.vram_wdata !== 8'h41) begin
      n_bad++;
      $display("FAIL single_hold: addr=%0d wdata=%h, required 205/41", bus.vram_addr, bus.vram_wdata);
    end
  endtask

  task automatic test_corner();
    int we0;
    set_cursor(7'd99, 6'd37);
    we0 = we_n;
    push_char(8'h5A);
    wait_idle(40, "corner");
    n_cmp += 2;
    if (we_n - we0 != 1 || wa[we0 % 4096] !== 12'd3799) begin
      n_bad++;
      $display("FAIL corner_addr: writes=%0d addr=%0d, required 1/3799", we_n - we0, wa[we0 % 4096]);
    end
    if (wd[we0 % 4096] !== 8'h5A) begin
      n_bad++; $display("FAIL corner_wdata: got %h, required 5a", wd[we0 % 4096]);
    end
  endtask

  task automatic test_newline(input logic [6:0] x, input int pulses, input string name);
    int we0, inc0, gap_bad;
    set_cursor(x, 6'd3);
    we0  = we_n;
    inc0 = inc_n;
    push_char(8'h0A);
    wait_idle(600, name);
    gap_bad = 0;
    for (int i = 1; i < pulses; i++) begin
      if (ic[(inc0 + i) % 4096] - ic[(inc0 + i - 1) % 4096] != 2) gap_bad++;
    end
    n_cmp += 3;
    if (inc_n - inc0 != pulses) begin
      n_bad++; $display("FAIL %s_pulses: got %0d, required %0d", name, inc_n - inc0, pulses);
    end
    if (we_n - we0 != 0) begin
      n_bad++; $display("FAIL %s_writes: got %0d, required 0", name, we_n - we0);
    end
    if (gap_bad != 0) begin
      n_bad++; $display("FAIL %s_spacing: %0d gaps not 2 cycles, required 0", name, gap_bad);
    end
  endtask

  task automatic test_back_to_back();
    int we0, inc0, k, guard, order_bad;
    logic saw_full;
    set_cursor(7'd0, 6'd0);
    we0      = we_n;
    inc0     = inc_n;
    k        = 0;
    guard    = 0;
    saw_full = 1'b0;
    while (k < 12 && guard < 400) begin
      bus.char_valid = 1'b1;
      bus.char_data  = 8'h30 + 8'(k);
      if (bus.char_ready === 1'b1) k++;
      else saw_full = 1'b1;
      step();
      guard++;
    end
    bus.char_valid = 1'b0;
    wait_idle(200, "b2b");
    order_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (wd[(we0 + i) % 4096] !== 8'h30 + 8'(i) || wa[(we0 + i) % 4096] !== AddrW'(i))
        order_bad++;
    end
    n_cmp += 6;
    if (k != 12) begin
      n_bad++; $display("FAIL b2b_accepted: got %0d, required 12", k);
    end
    if (saw_full !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_drop: saw_full=%b, required 1", saw_full);
    end
    if (we_n - we0 != 12) begin
      n_bad++; $display("FAIL b2b_writes: got %0d, required 12", we_n - we0);
    end
    if (inc_n - inc0 != 12) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d, required 12", inc_n - inc0);
    end
    if (order_bad != 0) begin
      n_bad++; $display("FAIL b2b_order: %0d entries out of order, required 0", order_bad);
    end
    if (bus.char_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_end: got %b, required 1", bus.char_ready);
    end
  endtask

  task automatic test_clear();
    int we0, inc0, bad;
    set_cursor(7'd10, 6'd4);
    we0  = we_n;
    inc0 = inc_n;
    push_char(8'h0C);
    wait_idle(5000, "clear");
`ifdef CLI_CLEAR_EN
    bad = 0;
    for (int i = 0; i < 3800; i++) begin
      if (wa[(we0 + i) % 4096] !== AddrW'(i) || wd[(we0 + i) % 4096] !== 8'h20) bad++;
    end
    n_cmp += 4;
    if (we_n - we0 != 3800) begin
      n_bad++; $display("FAIL clear_writes: got %0d, required 3800", we_n - we0);
    end
    if (inc_n - inc0 != 0) begin
      n_bad++; $display("FAIL clear_pulses: got %0d, required 0", inc_n - inc0);
    end
    if (bad != 0) begin
      n_bad++; $display("FAIL clear_cells: %0d bad cells, required 0", bad);
    end
    if (wc[(we0 + 3799) % 4096] - wc[we0 % 4096] != 3799) begin
      n_bad++;
      $display("FAIL clear_span: got %0d cycles, required 3799",
               wc[(we0 + 3799) % 4096] - wc[we0 % 4096]);
    end
`else
    bad = 0;
    n_cmp += 3;
    if (we_n - we0 != 1 || wd[we0 % 4096] !== 8'h0C) begin
      n_bad++;
      $display("FAIL ff_write: writes=%0d data=%h, required 1/0c", we_n - we0, wd[we0 % 4096]);
    end
    if (wa[we0 % 4096] !== 12'd410) begin
      n_bad++; $display("FAIL ff_addr: got %0d, required 410", wa[we0 % 4096]);
    end
    if (inc_n - inc0 != 1 + bad) begin
      n_bad++; $display("FAIL ff_pulses: got %0d, required 1", inc_n - inc0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int we0, inc0, k;
    set_cursor(7'd0, 6'd1);
    we0  = we_n;
    inc0 = inc_n;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h61;
    step();
    bus.char_data  = 8'h62;
    step();
    bus.char_data  = 8'h63;
    step();
    bus.char_valid = 1'b0;
    k = 0;
    while (bus.vram_we !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.vram_we !== 1'b1) begin
      n_bad++; $display("FAIL midrst_we_seen: got %b, required 1", bus.vram_we);
    end
    rst_n = 1'b0;
    step();
    n_cmp += 4;
    if (bus.vram_we !== 1'b0) begin
      n_bad++; $display("FAIL midrst_we: got %b, required 0", bus.vram_we);
    end
    if (bus.inc_ptr !== 1'b0) begin
      n_bad++; $display("FAIL midrst_inc: got %b, required 0", bus.inc_ptr);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_busy: got %b, required 0", bus.busy);
    end
    if (bus.char_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_ready: got %b, required 1", bus.char_ready);
    end
    rst_n = 1'b1;
    repeat (20) step();
    n_cmp += 2;
    if (we_n - we0 != 1) begin
      n_bad++; $display("FAIL midrst_dropped_writes: got %0d, required 1", we_n - we0);
    end
    if (inc_n - inc0 != 0) begin
      n_bad++; $display("FAIL midrst_dropped_pulses: got %0d, required 0", inc_n - inc0);
    end
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_data  = '0;
    test_reset();
    test_single();
    test_corner();
    test_newline(7'd97, 3,   "nl97");
    test_newline(7'd99, 1,   "nl99");
    test_newline(7'd0,  100, "nl0");
    test_back_to_back();
    test_clear();
    test_reset_mid();
    n_cmp++;
    if (both_n != 0) begin
      n_bad++; $display("FAIL we_inc_overlap: got %0d cycles, required 0", both_n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
